// File: rtl/intercon_bus_sched_pkg.sv
// Shared constants and state encoding for the intercon bus master scheduler.
package intercon_bus_sched_pkg;

  localparam int INTERCON_MASTER_NUM  = 4;
  localparam int INTERCON_BUS_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/intercon_bus_sched_rr_pick.sv
// Round-robin picker: first requester after last_onehot, wrapping, as a one-hot vector.
module intercon_bus_sched_rr_pick #(
  parameter int MASTER_NUM = 4
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MASTER_NUM-1:0] last_onehot,
  output logic [MASTER_NUM-1:0] winner
);

  logic [2*MASTER_NUM-1:0] req_dbl_s;
  logic [2*MASTER_NUM-1:0] base_s;
  logic [2*MASTER_NUM-1:0] pick_dbl_s;

  // Subtracting the start position from the doubled request vector clears every
  // request bit below it and the first set bit at or above it survives the mask.
  always_comb begin
    req_dbl_s  = {req, req};
    base_s     = {{(MASTER_NUM-1){1'b0}}, last_onehot, 1'b0};
    pick_dbl_s = req_dbl_s & ~(req_dbl_s - base_s);
    winner     = pick_dbl_s[MASTER_NUM-1:0] | pick_dbl_s[2*MASTER_NUM-1:MASTER_NUM];
  end

endmodule

// File: rtl/intercon_bus_sched.sv
// Shared-bus scheduler: CYC-framed round-robin ownership with a per-transfer
// watchdog that aborts an owner whose slave never acknowledges.
module intercon_bus_sched
  import intercon_bus_sched_pkg::*;
#(
  parameter int MASTER_NUM = INTERCON_MASTER_NUM,
  parameter int IDX_W      = $clog2(MASTER_NUM),
  parameter int TIMEOUT    = INTERCON_BUS_TIMEOUT,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] m_cyc,
  input  logic                  s_ack,
  input  logic                  s_err,
  output logic [MASTER_NUM-1:0] grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  bus_busy,
  output logic                  to_err
);

  localparam logic [CNT_W-1:0]      TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]      CNT_MAX_C  = (TIMEOUT == 0) ? {CNT_W{1'b1}} : TIMEOUT_C;
  localparam logic [MASTER_NUM-1:0] LAST_RST_C = {1'b1, {(MASTER_NUM-1){1'b0}}};

  sched_state_e          state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [MASTER_NUM-1:0] last_r;
  logic [MASTER_NUM-1:0] winner_s;
  logic [IDX_W-1:0]      winner_idx_s;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic                  owner_cyc_s;

  function automatic logic [IDX_W-1:0] onehot_enc(input logic [MASTER_NUM-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < MASTER_NUM; i++) begin
      idx = idx | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    return idx;
  endfunction

  intercon_bus_sched_rr_pick #(.MASTER_NUM(MASTER_NUM)) u_rr_pick (
    .req         (m_cyc),
    .last_onehot (last_r),
    .winner      (winner_s)
  );

  // Next-owner index, owner request and incremented watchdog count.
  always_comb begin
    winner_idx_s = onehot_enc(winner_s);
    owner_cyc_s  = |(m_cyc & grant);
    cnt_inc_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Ownership FSM with registered grant, index, busy flag and abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      last_r    <= LAST_RST_C;
      grant     <= {MASTER_NUM{1'b0}};
      grant_idx <= {IDX_W{1'b0}};
      bus_busy  <= 1'b0;
      to_err    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          to_err <= 1'b0;
          cnt_r  <= {CNT_W{1'b0}};
          if (|m_cyc) begin
            grant     <= winner_s;
            grant_idx <= winner_idx_s;
            bus_busy  <= 1'b1;
            last_r    <= winner_s;
            state_r   <= OWN;
          end else begin
            grant     <= {MASTER_NUM{1'b0}};
            grant_idx <= {IDX_W{1'b0}};
            bus_busy  <= 1'b0;
          end
        end
        OWN: begin
          // Release takes priority over ack and timeout on the same edge.
          if (!owner_cyc_s) begin
            grant     <= {MASTER_NUM{1'b0}};
            grant_idx <= {IDX_W{1'b0}};
            bus_busy  <= 1'b0;
            to_err    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= IDLE;
          end else if (s_ack || s_err) begin
            cnt_r  <= {CNT_W{1'b0}};
            to_err <= 1'b0;
          end else if ((TIMEOUT != 0) && (cnt_inc_s == TIMEOUT_C)) begin
            cnt_r   <= cnt_inc_s;
            to_err  <= 1'b1;
            state_r <= ABORT;
          end else if (cnt_r != CNT_MAX_C) begin
            cnt_r  <= cnt_inc_s;
            to_err <= 1'b0;
          end else begin
            to_err <= 1'b0;
          end
        end
        ABORT: begin
          to_err <= 1'b0;
          if (!owner_cyc_s) begin
            grant     <= {MASTER_NUM{1'b0}};
            grant_idx <= {IDX_W{1'b0}};
            bus_busy  <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= IDLE;
          end else begin
            state_r <= ABORT;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= {CNT_W{1'b0}};
          grant     <= {MASTER_NUM{1'b0}};
          grant_idx <= {IDX_W{1'b0}};
          bus_busy  <= 1'b0;
          to_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intercon_bus_sched.sv
// Directed bench for intercon_bus_sched with a short watchdog (TIMEOUT=8).
module tb_intercon_bus_sched;

  logic       clk;
  logic       rst;
  logic [3:0] m_cyc;
  logic       s_ack;
  logic       s_err;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       bus_busy;
  logic       to_err;

  int checks;
  int failures;

  intercon_bus_sched #(
    .MASTER_NUM (4),
    .IDX_W      (2),
    .TIMEOUT    (8),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_cyc     (m_cyc),
    .s_ack     (s_ack),
    .s_err     (s_err),
    .grant     (grant),
    .grant_idx (grant_idx),
    .bus_busy  (bus_busy),
    .to_err    (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] rot_exp [5];

  initial begin
    checks   = 0;
    failures = 0;
    rot_exp[0] = 4'b0001;
    rot_exp[1] = 4'b0010;
    rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000;
    rot_exp[4] = 4'b0001;
    rst   = 1'b1;
    m_cyc = 4'b0000;
    s_ack = 1'b0;
    s_err = 1'b0;
    tick(2);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_idx", 32'(grant_idx), 32'h0);
    chk("rst_busy", 32'(bus_busy), 32'h0);
    chk("rst_to_err", 32'(to_err), 32'h0);
    rst = 1'b0;

    // Reset priority: master 0 first, so 1010 picks master 1.
    m_cyc = 4'b1010;
    tick(1);
    chk("rstprio_grant", 32'(grant), 32'h2);
    chk("rstprio_idx", 32'(grant_idx), 32'h1);
    chk("rstprio_busy", 32'(bus_busy), 32'h1);
    m_cyc = 4'b0000;
    tick(1);
    chk("rstprio_release", 32'(grant), 32'h0);

    // Rotation with all masters requesting.
    rst = 1'b1;
    tick(1);
    rst   = 1'b0;
    m_cyc = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      tick(1);
      chk("rot_grant", 32'(grant), 32'(rot_exp[r]));
      s_ack = 1'b1;
      tick(3);
      s_ack = 1'b0;
      chk("rot_hold", 32'(grant), 32'(rot_exp[r]));
      m_cyc = 4'b1111 & ~rot_exp[r];
      tick(1);
      chk("rot_dead", 32'(grant), 32'h0);
      m_cyc = 4'b1111;
    end
    m_cyc = 4'b0000;
    tick(1);

    // No preemption: master 2 owns, master 0 raises CYC.
    m_cyc = 4'b0100;
    tick(1);
    chk("hold_grant", 32'(grant), 32'h4);
    m_cyc = 4'b0101;
    tick(3);
    chk("hold_nopreempt", 32'(grant), 32'h4);
    chk("hold_idx", 32'(grant_idx), 32'h2);
    m_cyc = 4'b0001;
    tick(1);
    chk("hold_dead_grant", 32'(grant), 32'h0);
    chk("hold_dead_busy", 32'(bus_busy), 32'h0);
    tick(1);
    chk("hold_next_grant", 32'(grant), 32'h1);
    chk("hold_next_idx", 32'(grant_idx), 32'h0);
    m_cyc = 4'b0000;
    tick(1);

    // Watchdog: master 1 owns with no ack, abort 8 cycles after grant.
    m_cyc = 4'b0010;
    tick(1);
    chk("wd_grant", 32'(grant), 32'h2);
    tick(7);
    chk("wd_before", 32'(to_err), 32'h0);
    tick(1);
    chk("wd_pulse", 32'(to_err), 32'h1);
    tick(1);
    chk("wd_pulse_end", 32'(to_err), 32'h0);
    chk("wd_abort_hold", 32'(grant), 32'h2);
    tick(10);
    chk("wd_no_repulse", 32'(to_err), 32'h0);
    chk("wd_abort_busy", 32'(bus_busy), 32'h1);
    m_cyc = 4'b0000;
    tick(1);
    chk("wd_release", 32'(grant), 32'h0);
    chk("wd_release_busy", 32'(bus_busy), 32'h0);

    // Ack on the timeout edge wins; then err also clears the counter.
    m_cyc = 4'b0010;
    tick(1);
    chk("ackto_grant", 32'(grant), 32'h2);
    tick(7);
    s_ack = 1'b1;
    tick(1);
    s_ack = 1'b0;
    chk("ackto_no_err", 32'(to_err), 32'h0);
    chk("ackto_hold", 32'(grant), 32'h2);
    tick(4);
    s_err = 1'b1;
    tick(1);
    s_err = 1'b0;
    tick(7);
    chk("ackto_err_cleared", 32'(to_err), 32'h0);
    tick(1);
    chk("ackto_late_pulse", 32'(to_err), 32'h1);
    m_cyc = 4'b0000;
    tick(1);
    chk("ackto_release", 32'(grant), 32'h0);

    // CYC drop on the timeout edge: clean release, no pulse.
    m_cyc = 4'b0100;
    tick(1);
    chk("dropto_grant", 32'(grant), 32'h4);
    tick(7);
    m_cyc = 4'b0000;
    tick(1);
    chk("dropto_no_err", 32'(to_err), 32'h0);
    chk("dropto_release", 32'(grant), 32'h0);

    // Async reset mid-ownership, then reset-priority regrant.
    m_cyc = 4'b1000;
    tick(1);
    chk("arst_pre_grant", 32'(grant), 32'h8);
    chk("arst_pre_idx", 32'(grant_idx), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_busy", 32'(bus_busy), 32'h0);
    chk("arst_to_err", 32'(to_err), 32'h0);
    m_cyc = 4'b1010;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("arst_regrant", 32'(grant), 32'h2);
    chk("arst_regrant_idx", 32'(grant_idx), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
